instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/address word width.
REQ-002 Parameter MEM_DEPTH, default 64, instruction memory depth in words.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker word.
REQ-004 i_clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_enable  input  1  load mode request from debug controller, level.
REQ-007 i_rx_byte  input  8  received UART byte, valid only with i_rx_valid.
REQ-008 i_rx_valid  input  1  one-cycle strobe, one byte per strobe.
REQ-009 o_instruccion  output  DATA_WIDTH  assembled word for I_FETCH instruction memory.
REQ-010 o_address  output  DATA_WIDTH  byte address of o_instruccion.
REQ-011 o_loading  output  1  one-cycle write strobe to I_FETCH.
REQ-012 o_done  output  1  level, program load complete.
REQ-013 o_overflow  output  1  level, program exceeded MEM_DEPTH words.

Function
REQ-014 States SHALL be IDLE, COLLECT, WRITE, DONE (plus CHECK, see Configuration).
REQ-015 IDLE: i_enable=1 SHALL go to COLLECT, clear byte counter to 0 and address to 0, clear o_done/o_overflow.
REQ-016 COLLECT: each i_rx_valid SHALL shift a byte in; first byte -> bits [31:24], fourth byte -> bits [7:0] (big-endian).
REQ-017 On the fourth byte, next cycle SHALL be WRITE with o_loading=1 for exactly one cycle; o_instruccion and o_address stable during that cycle.
REQ-018 WRITE SHALL last one cycle; a byte strobed during WRITE SHALL be accepted as byte 0 of the next word (no byte loss).
REQ-019 After WRITE, o_address SHALL increment by 4; wrap is impossible (see REQ-021).
REQ-020 If the written word equals HALT_WORD, WRITE SHALL go to DONE (or CHECK when enabled) instead of COLLECT.
REQ-021 If a write occurs at address (MEM_DEPTH-1)*4 and the word is not HALT_WORD, WRITE SHALL go to DONE with o_overflow=1.
REQ-022 DONE: o_done=1, further bytes ignored; i_enable=0 SHALL return to IDLE with o_done held until next IDLE->COLLECT.
REQ-023 i_enable=0 in COLLECT SHALL return to IDLE next cycle, discarding any partial word, no o_loading.
REQ-024 i_enable=0 in WRITE SHALL complete the write strobe then go to IDLE.
REQ-025 o_loading SHALL never be asserted outside WRITE.

Reset
REQ-026 i_reset=1 SHALL force IDLE, o_instruccion=0, o_address=0, o_loading=0, o_done=0, o_overflow=0, byte counter 0, from any state including mid-word.
REQ-027 Reset SHALL take priority over i_rx_valid and i_enable in the same cycle.

Configuration
REQ-028 Macro INSTR_LOADER_CHECKSUM_EN SHALL add state CHECK and output o_chk_error (1 bit, reset 0).
REQ-029 With macro: XOR of all received program bytes accumulated; after HALT_WORD write, CHECK takes next byte; mismatch sets o_chk_error=1; then DONE.
REQ-030 Without macro: no CHECK state, no o_chk_error port, HALT_WORD goes directly to DONE.

Verification
REQ-031 Enable, bytes 20 08 00 05, FF FF FF FF -> o_loading pulses twice: (0x20080005, addr 0) then (0xFFFFFFFF, addr 4); o_done=1.
REQ-032 Enable, bytes 12 34, drop i_enable, re-enable, bytes AA BB CC DD -> single write 0xAABBCCDD at address 0.
REQ-033 MEM_DEPTH=4, four non-halt words -> writes at 0,4,8,12 then o_overflow=1, o_done=1; fifth word bytes ignored.
REQ-034 Byte strobed in the WRITE cycle -> appears in [31:24] of the next word.
REQ-035 i_reset pulse after two bytes -> all outputs 0, IDLE; subsequent 4 bytes produce write at address 0.
REQ-036 Checksum build: program 00000001 + FFFFFFFF, checksum byte 0x01 -> o_chk_error=0; byte 0x00 -> o_chk_error=1.

Source files
------------

// File: rtl/instr_loader.sv
// Assembles big-endian UART bytes into instruction words and writes them to I_FETCH.
// Optional INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and o_chk_error.
module instr_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 64,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_overflow
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic                  o_chk_error
`endif
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = (NBYTES > 2) ? $clog2(NBYTES) : 1;

    localparam logic [CW-1:0]         LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'((MEM_DEPTH - 1) * 4);
    localparam logic [DATA_WIDTH-1:0] ADDR_STEP = DATA_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        S_CHECK
`endif
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-9:0] part_q, part_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
    logic                  chk_err_q, chk_err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        chk_d     = chk_q;
        chk_err_d = chk_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    chk_d     = '0;
                    chk_err_d = 1'b0;
`endif
                end
            end

            S_COLLECT: begin
                if (!i_enable) begin
                    // Partial word is dropped; byte count restarts next load
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (i_rx_valid) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ i_rx_byte;
`endif
                    if (cnt_q == LAST_BYTE) begin
                        instr_d = {part_q, i_rx_byte};
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        part_d = {part_q[DATA_WIDTH-17:0], i_rx_byte};
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
            end

            S_WRITE: begin
                addr_d = addr_q + ADDR_STEP;
                if (instr_q == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else if (!i_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_COLLECT;
                    // A byte landing on the write cycle starts the next word
                    if (i_rx_valid) begin
                        part_d = {part_q[DATA_WIDTH-17:0], i_rx_byte};
                        cnt_d  = CW'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                        chk_d  = chk_q ^ i_rx_byte;
`endif
                    end
                end
            end

            S_DONE: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end
            end

`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (i_rx_valid) begin
                    chk_err_d = (i_rx_byte != chk_q);
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    assign o_instruccion = instr_q;
    assign o_address     = addr_q;
    assign o_loading     = (state_q == S_WRITE);
    assign o_done        = done_q;
    assign o_overflow    = ovf_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign o_chk_error   = chk_err_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, hand sequences, random programs.
// Built with MEM_DEPTH=4 so overflow is reachable quickly.
module tb_instr_loader;

    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    rxb;
    logic          rxv;
    logic [DW-1:0] instr;
    logic [DW-1:0] addr;
    logic          loading;
    logic          done;
    logic          ovf;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic          chk_err;
`endif

    always #5 clk = ~clk;

    instr_loader #(
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_rx_byte    (rxb),
        .i_rx_valid   (rxv),
        .o_instruccion(instr),
        .o_address    (addr),
        .o_loading    (loading),
        .o_done       (done),
        .o_overflow   (ovf)
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        .o_chk_error  (chk_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] got_w[$];
    logic [31:0] got_a[$];
    logic [7:0]  stim_q[$];
    logic [31:0] exp_w[$];
    bit          exp_done;
    bit          exp_ovf;

    always @(negedge clk) begin
        if (loading) begin
            got_w.push_back(instr);
            got_a.push_back(addr);
        end
    end

    typedef struct {
        string             name;
        int                n;
        logic [0:23][7:0]  b;
        int                gap;
        int                nw;
        logic [0:4][31:0]  w;
        bit                done;
        bit                ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rxb = b;
        rxv = 1'b1;
        tick();
        rxv = 1'b0;
    endtask

    task automatic start();
        en = 1'b0;
        tick();
        tick();
        got_w.delete();
        got_a.delete();
        en = 1'b1;
        tick();
    endtask

    // Reference: words are consecutive byte quads; loading stops at the
    // halt word or once DEPTH words have been written.
    function automatic void run_model();
        logic [31:0] w;
        exp_w.delete();
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        for (int i = 0; i + 3 < stim_q.size(); i += 4) begin
            w = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
            exp_w.push_back(w);
            if (w == HALT) begin
                exp_done = 1'b1;
                break;
            end
            if (exp_w.size() == DEPTH) begin
                exp_done = 1'b1;
                exp_ovf  = 1'b1;
                break;
            end
        end
    endfunction

    task automatic check_exp(input string nm);
        chk($sformatf("%s.count", nm), got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk($sformatf("%s.w%0d", nm, i), got_w[i], exp_w[i]);
            chk($sformatf("%s.a%0d", nm, i), got_a[i], 32'(i * 4));
        end
        chk($sformatf("%s.done", nm), done, exp_done);
        chk($sformatf("%s.ovf", nm), ovf, exp_ovf);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".instr"}, instr, 32'h0);
        chk({nm, ".addr"}, addr, 32'h0);
        chk({nm, ".loading"}, loading, 32'h0);
        chk({nm, ".done"}, done, 32'h0);
        chk({nm, ".ovf"}, ovf, 32'h0);
    endtask

    initial begin
        tbl[0] = '{"halt2", 8,
                   {8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 128'h0},
                   0, 2, {32'h20080005, 32'hFFFFFFFF, 96'h0}, 1'b1, 1'b0};
        tbl[1] = '{"ovf", 20,
                   {8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24,
                    8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44,
                    8'h51, 8'h52, 8'h53, 8'h54, 32'h0},
                   0, 4, {32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344, 32'h0},
                   1'b1, 1'b1};
        tbl[2] = '{"halt1", 8,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 128'h0},
                   1, 1, {32'hFFFFFFFF, 128'h0}, 1'b1, 1'b0};
        tbl[3] = '{"partial", 3,
                   {8'h12, 8'h34, 8'h56, 168'h0},
                   2, 0, 160'h0, 1'b0, 1'b0};
        tbl[4] = '{"nearhalt", 8,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 128'h0},
                   0, 2, {32'hFFFFFFFE, 32'hFFFFFFFF, 96'h0}, 1'b1, 1'b0};
        tbl[5] = '{"halt_last", 16,
                   {8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
                    8'h03, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 64'h0},
                   1, 4, {32'h01010101, 32'h02020202, 32'h03030303, 32'hFFFFFFFF, 32'h0},
                   1'b1, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        rxv = 1'b0;
        rxb = 8'h00;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            start();
            for (int i = 0; i < tbl[t].n; i++) begin
                send(tbl[t].b[i]);
                repeat (tbl[t].gap) tick();
            end
            repeat (4) tick();
            chk($sformatf("%s.count", tbl[t].name), got_w.size(), tbl[t].nw);
            for (int i = 0; i < tbl[t].nw && i < got_w.size(); i++) begin
                chk($sformatf("%s.w%0d", tbl[t].name, i), got_w[i], tbl[t].w[i]);
                chk($sformatf("%s.a%0d", tbl[t].name, i), got_a[i], 32'(i * 4));
            end
            chk({tbl[t].name, ".done"}, done, tbl[t].done);
            chk({tbl[t].name, ".ovf"}, ovf, tbl[t].ovf);
        end

        // done is held through IDLE and cleared on re-entry to COLLECT
        en = 1'b0;
        tick();
        tick();
        chk("hold.done", done, 32'h1);
        en = 1'b1;
        tick();
        chk("rearm.done", done, 32'h0);
        chk("rearm.addr", addr, 32'h0);

        // Enable drop mid-word discards the partial word
        start();
        send(8'h12);
        send(8'h34);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        repeat (3) tick();
        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_model();
        check_exp("drop");

        // Byte strobed during the write cycle opens the next word
        start();
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h06, 8'h07, 8'h08};
        foreach (stim_q[i]) send(stim_q[i]);
        repeat (3) tick();
        run_model();
        check_exp("wbyte");

        // Enable drop during the write cycle still completes the write
        start();
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        send(8'h0D);
        chk("wdrop.loading", loading, 32'h1);
        en = 1'b0;
        tick();
        chk("wdrop.after", loading, 32'h0);
        tick();
        en = 1'b1;
        tick();
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        repeat (3) tick();
        chk("wdrop.count", got_w.size(), 32'd2);
        if (got_w.size() == 2) begin
            chk("wdrop.w0", got_w[0], 32'h0A0B0C0D);
            chk("wdrop.a0", got_a[0], 32'h0);
            chk("wdrop.w1", got_w[1], 32'hDEADBEEF);
            chk("wdrop.a1", got_a[1], 32'h0);
        end

        // Reset from DONE
        start();
        send(8'hFF);
        send(8'hFF);
        send(8'hFF);
        send(8'hFF);
        repeat (2) tick();
        chk("pre_rst.done", done, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_done");

        // Reset mid-word wins over simultaneous enable and byte strobe
        start();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        send(8'h66);
        rst = 1'b1;
        rxv = 1'b1;
        rxb = 8'h77;
        tick();
        rst = 1'b0;
        rxv = 1'b0;
        check_zero("rst_mid");
        tick();
        send(8'h9A);
        send(8'hBC);
        send(8'hDE);
        send(8'hF0);
        repeat (3) tick();
        chk("rst_mid.count", got_w.size(), 32'd2);
        if (got_w.size() == 2) begin
            chk("rst_mid.w1", got_w[1], 32'h9ABCDEF0);
            chk("rst_mid.a1", got_a[1], 32'h0);
        end

        for (int r = 0; r < 25; r++) begin
            int nw;
            int tail;
            logic [31:0] w;
            start();
            stim_q.delete();
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
                stim_q.push_back(w[31:24]);
                stim_q.push_back(w[23:16]);
                stim_q.push_back(w[15:8]);
                stim_q.push_back(w[7:0]);
            end
            tail = $urandom_range(0, 3);
            repeat (tail) stim_q.push_back(8'($urandom));
            run_model();
            foreach (stim_q[i]) begin
                send(stim_q[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
            repeat (4) tick();
            check_exp($sformatf("rand%0d", r));
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        for (int c = 0; c < 2; c++) begin
            start();
            send(8'h00);
            send(8'h00);
            send(8'h00);
            send(8'h01);
            send(8'hFF);
            send(8'hFF);
            send(8'hFF);
            send(8'hFF);
            tick();
            send((c == 0) ? 8'h01 : 8'h00);
            repeat (2) tick();
            chk($sformatf("chk%0d.err", c), chk_err, 32'(c));
            chk($sformatf("chk%0d.done", c), done, 32'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
